// File: rtl/dev_io_sequencer.sv
// dev_io_sequencer
//   Moves 5-bit characters between a host stream and the core's device I/O
//   handshakes. Host characters are queued in an input FIFO and offered to the
//   core one at a time. An idle gap follows each accepted character, which
//   emulates the pace of a tape reader. Core output characters are captured
//   into an output FIFO that the host drains (first-word fall-through).
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   host_in_data/val/rdy            host -> input FIFO
//   host_out_data/val/rdy           output FIFO -> host
//   dev_input_rdy/val/data          input FIFO -> core (registered val/data)
//   dev_output_rdy/data/ack         core -> output FIFO, one-cycle ack
//   in_level, out_level             FIFO occupancies
//
// Input FSM
//   state     | meaning
//   I_IDLE    | waiting for a queued character and a ready core
//   I_PRESENT | character on dev_input_data, waiting for the core to take it
//   I_GAP     | enforced idle time after an accepted character
//
// Output FSM
//   state     | meaning
//   O_IDLE    | waiting for the core to offer a character (and FIFO room)
//   O_ACK     | ack pulse high for this one cycle
//   O_WAIT    | waiting for the core to drop its request

module dev_io_sequencer #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4,
  parameter int DW         = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          host_in_data,
  input  logic                   host_in_val,
  output logic                   host_in_rdy,
  output logic [DW-1:0]          host_out_data,
  output logic                   host_out_val,
  input  logic                   host_out_rdy,
  input  logic                   dev_input_rdy,
  output logic                   dev_input_val,
  output logic [DW-1:0]          dev_input_data,
  input  logic                   dev_output_rdy,
  input  logic [DW-1:0]          dev_output_data,
  output logic                   dev_output_ack,
  output logic [$clog2(DEPTH):0] in_level,
  output logic [$clog2(DEPTH):0] out_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {I_IDLE, I_PRESENT, I_GAP} i_state_e;
  typedef enum logic [1:0] {O_IDLE, O_ACK, O_WAIT} o_state_e;

  // ---------------- input FIFO ----------------
  logic [DW-1:0] in_mem_q [DEPTH];
  logic [AW-1:0] in_wr_q, in_rd_q;
  logic [LW-1:0] in_lvl_q;
  logic          in_push, in_pop;

  assign host_in_rdy = (in_lvl_q != FULL);
  assign in_push     = host_in_val && host_in_rdy;
  assign in_level    = in_lvl_q;

  always_ff @(posedge clk) begin
    if (in_push) in_mem_q[in_wr_q] <= host_in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      in_lvl_q <= '0;
    end else begin
      if (in_push) in_wr_q <= in_wr_q + AW'(1);
      if (in_pop)  in_rd_q <= in_rd_q + AW'(1);
      case ({in_push, in_pop})
        2'b10:   in_lvl_q <= in_lvl_q + LW'(1);
        2'b01:   in_lvl_q <= in_lvl_q - LW'(1);
        default: in_lvl_q <= in_lvl_q;
      endcase
    end
  end

  // ---------------- output FIFO ----------------
  logic [DW-1:0] out_mem_q [DEPTH];
  logic [AW-1:0] out_wr_q, out_rd_q;
  logic [LW-1:0] out_lvl_q;
  logic          out_push, out_pop;

  assign host_out_val  = (out_lvl_q != '0);
  assign host_out_data = out_mem_q[out_rd_q];
  assign out_pop       = host_out_val && host_out_rdy;
  assign out_level     = out_lvl_q;

  always_ff @(posedge clk) begin
    if (out_push) out_mem_q[out_wr_q] <= dev_output_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_lvl_q <= '0;
    end else begin
      if (out_push) out_wr_q <= out_wr_q + AW'(1);
      if (out_pop)  out_rd_q <= out_rd_q + AW'(1);
      case ({out_push, out_pop})
        2'b10:   out_lvl_q <= out_lvl_q + LW'(1);
        2'b01:   out_lvl_q <= out_lvl_q - LW'(1);
        default: out_lvl_q <= out_lvl_q;
      endcase
    end
  end

  // ---------------- input FSM ----------------
  i_state_e      i_state_q, i_state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          in_val_q, in_val_d;
  logic [DW-1:0] in_data_q, in_data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      i_state_q <= I_IDLE;
      gap_q     <= '0;
      in_val_q  <= 1'b0;
      in_data_q <= '0;
    end else begin
      i_state_q <= i_state_d;
      gap_q     <= gap_d;
      in_val_q  <= in_val_d;
      in_data_q <= in_data_d;
    end
  end

  always_comb begin
    i_state_d = i_state_q;
    gap_d     = gap_q;
    case (i_state_q)
      I_IDLE: begin
        if (in_lvl_q != '0 && dev_input_rdy) i_state_d = I_PRESENT;
      end
      I_PRESENT: begin
        if (dev_input_rdy) begin
          if (GAP_CYCLES == 0) begin
            i_state_d = I_IDLE;
          end else begin
            i_state_d = I_GAP;
            gap_d     = GW'(GAP_CYCLES);
          end
        end
      end
      I_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) i_state_d = I_IDLE;
      end
      default: i_state_d = I_IDLE;
    endcase
  end

  // The head is popped as it is latched into the presentation register, so
  // the FIFO slot frees one cycle before the core actually takes it.
  always_comb begin
    in_pop    = 1'b0;
    in_val_d  = in_val_q;
    in_data_d = in_data_q;
    case (i_state_q)
      I_IDLE: begin
        if (in_lvl_q != '0 && dev_input_rdy) begin
          in_pop    = 1'b1;
          in_val_d  = 1'b1;
          in_data_d = in_mem_q[in_rd_q];
        end
      end
      I_PRESENT: begin
        if (dev_input_rdy) in_val_d = 1'b0;
      end
      default: in_val_d = 1'b0;
    endcase
  end

  assign dev_input_val  = in_val_q;
  assign dev_input_data = in_data_q;

  // ---------------- output FSM ----------------
  o_state_e o_state_q, o_state_d;
  logic     ack_q, ack_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_state_q <= O_IDLE;
      ack_q     <= 1'b0;
    end else begin
      o_state_q <= o_state_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    o_state_d = o_state_q;
    case (o_state_q)
      O_IDLE:  if (dev_output_rdy && out_lvl_q != FULL) o_state_d = O_ACK;
      O_ACK:   o_state_d = O_WAIT;
      O_WAIT:  if (!dev_output_rdy) o_state_d = O_IDLE;
      default: o_state_d = O_IDLE;
    endcase
  end

  // Room is judged on the current level only; a host pop in the same cycle
  // does not let a capture through.
  always_comb begin
    out_push = (o_state_q == O_IDLE) && dev_output_rdy && (out_lvl_q != FULL);
    ack_d    = out_push;
  end

  assign dev_output_ack = ack_q;

endmodule

// File: tb/tb_dev_io_sequencer.sv
module tb_dev_io_sequencer;

  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] host_in_data;
  logic          host_in_val;
  logic          host_in_rdy;
  logic [DW-1:0] host_out_data;
  logic          host_out_val;
  logic          host_out_rdy;
  logic          dev_input_rdy;
  logic          dev_input_val;
  logic [DW-1:0] dev_input_data;
  logic          dev_output_rdy;
  logic [DW-1:0] dev_output_data;
  logic          dev_output_ack;
  logic [3:0]    in_level;
  logic [3:0]    out_level;

  dev_io_sequencer #(.DEPTH(8), .GAP_CYCLES(4), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .host_in_data(host_in_data), .host_in_val(host_in_val), .host_in_rdy(host_in_rdy),
    .host_out_data(host_out_data), .host_out_val(host_out_val), .host_out_rdy(host_out_rdy),
    .dev_input_rdy(dev_input_rdy), .dev_input_val(dev_input_val), .dev_input_data(dev_input_data),
    .dev_output_rdy(dev_output_rdy), .dev_output_data(dev_output_data),
    .dev_output_ack(dev_output_ack),
    .in_level(in_level), .out_level(out_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_in_q[$];
  logic [DW-1:0] exp_out_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: a transfer happens at the next rising edge whenever
  // val and rdy are both high mid-cycle.
  always @(negedge clk) begin
    if (!reset && dev_input_val && dev_input_rdy) begin
      if (exp_in_q.size() == 0) check("dev_in_unexpected", int'(dev_input_data), -1);
      else check("dev_in_data", int'(dev_input_data), int'(exp_in_q.pop_front()));
    end
    if (!reset && host_out_val && host_out_rdy) begin
      if (exp_out_q.size() == 0) check("host_out_unexpected", int'(host_out_data), -1);
      else check("host_out_data", int'(host_out_data), int'(exp_out_q.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int acks;
    reset = 1'b1;
    host_in_data = '0; host_in_val = 1'b0; host_out_rdy = 1'b0;
    dev_input_rdy = 1'b0; dev_output_rdy = 1'b0; dev_output_data = '0;

    // reset state
    tick();
    check("rst_host_in_rdy", host_in_rdy, 1);
    check("rst_host_out_val", host_out_val, 0);
    check("rst_dev_input_val", dev_input_val, 0);
    check("rst_ack", dev_output_ack, 0);
    check("rst_in_level", in_level, 0);
    check("rst_out_level", out_level, 0);
    reset = 1'b0;
    tick();

    // input latency and gap
    dev_input_rdy = 1'b1;
    host_in_val = 1'b1; host_in_data = 5'o21; exp_in_q.push_back(5'o21);
    tick();
    host_in_data = 5'o05; exp_in_q.push_back(5'o05);
    tick();
    host_in_val = 1'b0;
    check("lat_val", dev_input_val, 1);
    check("lat_data", dev_input_data, 5'o21);
    check("lat_push_pop_level", in_level, 1);
    tick();
    check("lat_consumed", dev_input_val, 0);
    n = 0;
    while (!dev_input_val && n < 20) begin tick(); n++; end
    check("gap_cycles", n, 5);
    check("gap_second_data", dev_input_data, 5'o05);
    tick();
    dev_input_rdy = 1'b0;
    repeat (6) tick();

    // core not ready
    host_in_val = 1'b1; host_in_data = 5'o13; exp_in_q.push_back(5'o13);
    tick();
    host_in_val = 1'b0;
    repeat (3) tick();
    check("stall_val", dev_input_val, 0);
    check("stall_level", in_level, 1);
    dev_input_rdy = 1'b1;
    tick();
    dev_input_rdy = 1'b0;
    check("rdy_val", dev_input_val, 1);
    check("rdy_data", dev_input_data, 5'o13);
    repeat (2) tick();
    check("hold_val", dev_input_val, 1);
    check("hold_data", dev_input_data, 5'o13);
    dev_input_rdy = 1'b1;
    tick();
    check("hold_consumed", dev_input_val, 0);
    dev_input_rdy = 1'b0;
    repeat (6) tick();

    // input full
    for (int i = 0; i < 8; i++) begin
      host_in_val = 1'b1; host_in_data = DW'(i + 1); exp_in_q.push_back(DW'(i + 1));
      tick();
    end
    check("full_rdy", host_in_rdy, 0);
    check("full_level", in_level, 8);
    host_in_data = 5'd9;
    tick();
    check("full_ninth_rejected", in_level, 8);
    dev_input_rdy = 1'b1;
    tick();
    check("full_pop_level", in_level, 7);
    check("full_pop_data", dev_input_data, 1);
    exp_in_q.push_back(5'd9);
    tick();
    host_in_val = 1'b0;
    check("refill_level", in_level, 8);
    check("refill_rdy", host_in_rdy, 0);
    n = 0;
    while ((in_level != 0 || dev_input_val) && n < 200) begin tick(); n++; end
    check("in_drain_in_time", int'(n < 200), 1);
    repeat (6) tick();
    dev_input_rdy = 1'b0;
    check("in_queue_empty", exp_in_q.size(), 0);

    // output capture
    dev_output_rdy = 1'b1; dev_output_data = 5'o27; exp_out_q.push_back(5'o27);
    acks = 0;
    repeat (10) begin tick(); if (dev_output_ack) acks++; end
    check("cap_one_ack", acks, 1);
    check("cap_level", out_level, 1);
    dev_output_rdy = 1'b0;
    repeat (2) tick();
    dev_output_rdy = 1'b1; dev_output_data = 5'o02; exp_out_q.push_back(5'o02);
    tick();
    check("cap2_ack", dev_output_ack, 1);
    check("cap2_level", out_level, 2);
    dev_output_rdy = 1'b0;
    tick();
    check("cap2_ack_pulse", dev_output_ack, 0);
    tick();
    host_out_rdy = 1'b1;
    repeat (2) tick();
    host_out_rdy = 1'b0;
    check("read_level", out_level, 0);
    check("read_val", host_out_val, 0);

    // output full
    for (int i = 0; i < 8; i++) begin
      dev_output_rdy = 1'b1; dev_output_data = DW'(10 + i); exp_out_q.push_back(DW'(10 + i));
      tick();
      dev_output_rdy = 1'b0;
      repeat (2) tick();
    end
    check("ofull_level", out_level, 8);
    dev_output_rdy = 1'b1; dev_output_data = 5'd31;
    acks = 0;
    repeat (3) begin tick(); if (dev_output_ack) acks++; end
    check("ofull_no_ack", acks, 0);
    host_out_rdy = 1'b1;
    tick();
    host_out_rdy = 1'b0;
    check("ofull_same_cycle_pop_no_ack", dev_output_ack, 0);
    check("ofull_pop_level", out_level, 7);
    exp_out_q.push_back(5'd31);
    tick();
    dev_output_rdy = 1'b0;
    check("ofull_ack_after_pop", dev_output_ack, 1);
    check("ofull_refill_level", out_level, 8);
    host_out_rdy = 1'b1;
    repeat (8) tick();
    host_out_rdy = 1'b0;
    check("odrain_level", out_level, 0);
    check("out_queue_empty", exp_out_q.size(), 0);

    // reset mid-operation
    host_in_val = 1'b1; host_in_data = 5'o07;
    tick();
    host_in_data = 5'o10;
    tick();
    host_in_val = 1'b0;
    exp_in_q.push_back(5'o07); exp_in_q.push_back(5'o10);
    dev_output_rdy = 1'b1; dev_output_data = 5'o03;
    dev_input_rdy = 1'b1;
    tick();
    check("pre_rst_val", dev_input_val, 1);
    check("pre_rst_ack", dev_output_ack, 1);
    reset = 1'b1;
    dev_input_rdy = 1'b0; dev_output_rdy = 1'b0;
    exp_in_q.delete(); exp_out_q.delete();
    tick();
    check("mid_rst_val", dev_input_val, 0);
    check("mid_rst_data", dev_input_data, 0);
    check("mid_rst_ack", dev_output_ack, 0);
    check("mid_rst_in_level", in_level, 0);
    check("mid_rst_out_level", out_level, 0);
    check("mid_rst_host_in_rdy", host_in_rdy, 1);
    reset = 1'b0;
    dev_input_rdy = 1'b1;
    repeat (5) tick();
    check("post_rst_idle", dev_input_val, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
